// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - parametrised universal shift register with self-timed serialiser
//
// Optional feature macro: SHREG_PARITY_EN (adds the parity output).
// Ports:
//   clk    in           rising-edge clock
//   clr    in           synchronous reset, active-high, overrides every other input
//   en     in           clock enable for mode ops and serialiser shifts
//   mode   in  [2:0]    operation select when idle
//   d      in  [W-1:0]  parallel load data (LOAD and serialiser start)
//   di_l   in           serial in at MSB (right shifts)
//   di_r   in           serial in at LSB (left shifts)
//   start  in           serialiser start pulse
//   q      out [W-1:0]  register contents
//   do_r   out          q[0]
//   do_l   out          q[WIDTH-1]
//   busy   out          serialiser active
//   done   out          one-cycle pulse on the last serialiser shift
//   parity out          ^q, only when SHREG_PARITY_EN is defined

module shift_reg_universal #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             di_l,
   input  logic             di_r,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             do_r,
   output logic             do_l,
   output logic             busy,
`ifdef SHREG_PARITY_EN
   output logic             done,
   output logic             parity
`else
   output logic             done
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHR   = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_ROR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_CLEAR = 3'b111;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         q     <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         state <= S_IDLE;
      end else begin
         // done is a single-cycle pulse: cleared unless the final shift re-asserts it
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // start wins over mode and does not need en
               if (start) begin
                  q     <= d;
                  cnt   <= CNT_W'(WIDTH);
                  busy  <= 1'b1;
                  state <= S_SHIFT;
               end else if (en) begin
                  case (mode)
                     MODE_SHR:   q <= {di_l, q[WIDTH-1:1]};
                     MODE_SHL:   q <= {q[WIDTH-2:0], di_r};
                     MODE_ROR:   q <= {q[0], q[WIDTH-1:1]};
                     MODE_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
                     MODE_LOAD:  q <= d;
                     MODE_ASR:   q <= {q[WIDTH-1], q[WIDTH-1:1]};
                     MODE_CLEAR: q <= '0;
                     MODE_HOLD:  q <= q;
                     default:    q <= q;
                  endcase
               end
            end
            S_SHIFT: begin
               // mode and start are ignored while a frame is in flight; en=0 stalls
               if (en) begin
                  q   <= {di_l, q[WIDTH-1:1]};
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign do_r = q[0];
   assign do_l = q[WIDTH-1];

`ifdef SHREG_PARITY_EN
   assign parity = ^q;
`endif

endmodule
